// File: rtl/soc_periph_demux.sv
// Single-master to multi-peripheral request router with an in-order response path.
// Unmapped requests are completed by an internal error responder one cycle after grant.

module soc_periph_demux_win #(
    parameter logic [63:0] Base = 64'h0,
    parameter logic [63:0] Len  = 64'h0
) (
    input  logic [63:0] addr,
    output logic        hit
);
    // Offset compare avoids overflow when Base+Len would wrap past 2^64.
    assign hit = (addr >= Base) && ((addr - Base) < Len);
endmodule

module soc_periph_demux #(
    parameter int NrSlaves = 5,
    parameter int MaxTrans = 4,
    parameter int CntWidth = $clog2(MaxTrans + 1)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         mst_req_i,
    input  logic [63:0]                  mst_addr_i,
    input  logic                         mst_we_i,
    input  logic [7:0]                   mst_be_i,
    input  logic [63:0]                  mst_wdata_i,
    output logic                         mst_gnt_o,
    output logic                         mst_rvalid_o,
    output logic [63:0]                  mst_rdata_o,
    output logic                         mst_err_o,
    output logic [NrSlaves-1:0]          slv_req_o,
    output logic [63:0]                  slv_addr_o,
    output logic                         slv_we_o,
    output logic [7:0]                   slv_be_o,
    output logic [63:0]                  slv_wdata_o,
    input  logic [NrSlaves-1:0]          slv_gnt_i,
    input  logic [NrSlaves-1:0]          slv_rvalid_i,
    input  logic [NrSlaves-1:0][63:0]    slv_rdata_i,
    input  logic [NrSlaves-1:0]          slv_err_i
);
    localparam int TgtWidth = $clog2(NrSlaves + 1);
    typedef logic [TgtWidth-1:0] tgt_t;
    localparam tgt_t TgtErr = tgt_t'(NrSlaves);
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxTrans);

    // Fixed SoC map, indexed DRAM, GPIO, UART, CLINT, Debug from bit 0 upward.
    localparam logic [4:0][63:0] MapBase = {
        64'h0000_0000, 64'h0200_0000, 64'h1000_0000, 64'h4000_0000, 64'h8000_0000};
    localparam logic [4:0][63:0] MapLen = {
        64'h0000_1000, 64'h000C_0000, 64'h0000_1000, 64'h0000_1000, 64'h4000_0000};

    logic [NrSlaves-1:0] hit;
    logic [NrSlaves-1:0] sel_mask;
    logic [NrSlaves-1:0] req;
    tgt_t                tgt;
    tgt_t                cur_tgt;
    logic [CntWidth-1:0] cnt;
    logic                err_pend;
    logic                gnt;
    logic                issue_ok;
    logic                rsp_valid;
    logic                rsp_fire;
    logic [63:0]         rsp_rdata;
    logic                rsp_err;

    for (genvar g = 0; g < NrSlaves; g++) begin : g_win
        if (g < 5) begin : g_map
            soc_periph_demux_win #(
                .Base(MapBase[g]),
                .Len (MapLen[g])
            ) u_win (
                .addr(mst_addr_i),
                .hit (hit[g])
            );
        end else begin : g_nomap
            assign hit[g] = 1'b0;
        end
    end

    always_comb begin
        tgt = TgtErr;
        for (int i = 0; i < NrSlaves; i++)
            if (hit[i]) tgt = tgt_t'(i);
    end

    // When cur_tgt is ERR no slave matches and the error responder drives the response.
    always_comb begin
        rsp_valid = err_pend;
        rsp_err   = err_pend;
        rsp_rdata = '0;
        sel_mask  = '0;
        for (int i = 0; i < NrSlaves; i++) begin
            if (cur_tgt == tgt_t'(i)) begin
                rsp_valid   = slv_rvalid_i[i];
                rsp_err     = slv_err_i[i];
                rsp_rdata   = slv_rdata_i[i];
                sel_mask[i] = 1'b1;
            end
        end
    end

    assign rsp_fire = rsp_valid && (cnt != '0);

    // A full counter still accepts a same-target request when a response retires this cycle.
    assign issue_ok = (cnt == '0) ||
                      ((tgt == cur_tgt) && ((cnt < CntMax) || rsp_fire));

    always_comb begin
        req = '0;
        gnt = 1'b0;
        if (issue_ok) begin
            if (tgt == TgtErr) begin
                gnt = mst_req_i;
            end else begin
                for (int i = 0; i < NrSlaves; i++) begin
                    if (tgt == tgt_t'(i)) begin
                        req[i] = mst_req_i;
                        gnt    = mst_req_i & slv_gnt_i[i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt      <= '0;
            cur_tgt  <= '0;
            err_pend <= 1'b0;
        end else begin
            if (gnt) cur_tgt <= tgt;
            err_pend <= gnt && (tgt == TgtErr);
            case ({gnt, rsp_fire})
                2'b10:   cnt <= cnt + CntWidth'(1);
                2'b01:   cnt <= cnt - CntWidth'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign mst_gnt_o    = rst_ni & gnt;
    assign mst_rvalid_o = rst_ni & rsp_fire;
    assign mst_err_o    = rst_ni & rsp_fire & rsp_err;
    assign mst_rdata_o  = (rst_ni && rsp_fire) ? rsp_rdata : '0;
    assign slv_req_o    = rst_ni ? req : '0;

    assign slv_addr_o  = mst_addr_i;
    assign slv_we_o    = mst_we_i;
    assign slv_be_o    = mst_be_i;
    assign slv_wdata_o = mst_wdata_i;

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(|(slv_rvalid_i & ~sel_mask)))
                else $warning("soc_periph_demux: rvalid from non-selected slave dropped");
            assert (!((cnt == '0) && (|slv_rvalid_i)))
                else $warning("soc_periph_demux: rvalid with nothing outstanding dropped");
        end
    end
`endif

endmodule

// File: tb/tb_soc_periph_demux.sv
// Scenario bench for soc_periph_demux; responses are checked against a queue of
// expectations pushed at grant time.

module tb_soc_periph_demux;
    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             mst_req = 1'b0;
    logic [63:0]      mst_addr = '0;
    logic             mst_we = 1'b0;
    logic [7:0]       mst_be = 8'hFF;
    logic [63:0]      mst_wdata = '0;
    logic             mst_gnt, mst_rvalid, mst_err;
    logic [63:0]      mst_rdata;
    logic [4:0]       slv_req;
    logic [63:0]      slv_addr, slv_wdata;
    logic             slv_we;
    logic [7:0]       slv_be;
    logic [4:0]       slv_gnt = '0, slv_rvalid = '0, slv_err = '0;
    logic [4:0][63:0] slv_rdata = '0;

    typedef struct packed {
        logic [63:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t mon_e;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    soc_periph_demux dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .mst_req_i   (mst_req),
        .mst_addr_i  (mst_addr),
        .mst_we_i    (mst_we),
        .mst_be_i    (mst_be),
        .mst_wdata_i (mst_wdata),
        .mst_gnt_o   (mst_gnt),
        .mst_rvalid_o(mst_rvalid),
        .mst_rdata_o (mst_rdata),
        .mst_err_o   (mst_err),
        .slv_req_o   (slv_req),
        .slv_addr_o  (slv_addr),
        .slv_we_o    (slv_we),
        .slv_be_o    (slv_be),
        .slv_wdata_o (slv_wdata),
        .slv_gnt_i   (slv_gnt),
        .slv_rvalid_i(slv_rvalid),
        .slv_rdata_i (slv_rdata),
        .slv_err_i   (slv_err)
    );

    // Response scoreboard: every forwarded response must match the oldest expectation.
    always @(negedge clk) begin
        if (mst_rvalid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rsp_unexpected got rdata=%h err=%b want none", mst_rdata, mst_err);
            end else begin
                mon_e = exp_q.pop_front();
                if ({mst_rdata, mst_err} !== mon_e) begin
                    bad++;
                    $display("FAIL rsp_data got rdata=%h err=%b want rdata=%h err=%b",
                             mst_rdata, mst_err, mon_e.rdata, mon_e.err);
                end
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mst_req    = 1'b0;
        slv_gnt    = '0;
        slv_rvalid = '0;
        slv_err    = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mst_req = 1'b1;
        mst_addr = 64'h2000_0000;
        slv_gnt = '1;
        @(negedge clk);
        total++;
        if ({mst_gnt, mst_rvalid, mst_err, slv_req, mst_rdata} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got gnt=%b rv=%b err=%b req=%b rdata=%h want 0",
                     mst_gnt, mst_rvalid, mst_err, slv_req, mst_rdata);
        end
        next();
        idle();
        rst_n = 1'b1;
        next();
        total++;
        if ({dut.cnt, dut.cur_tgt, dut.err_pend} !== '0) begin
            bad++;
            $display("FAIL reset_state got cnt=%0d tgt=%0d ep=%b want 0",
                     dut.cnt, dut.cur_tgt, dut.err_pend);
        end
    endtask

    task automatic test_uart_read();
        mst_req = 1'b1;
        mst_addr = 64'h1000_0008;
        slv_gnt = 5'b00100;
        @(negedge clk);
        total++;
        if (slv_req !== 5'b00100 || mst_gnt !== 1'b1 || slv_addr !== 64'h1000_0008) begin
            bad++;
            $display("FAIL uart_issue got req=%b gnt=%b addr=%h want 00100/1/1000_0008",
                     slv_req, mst_gnt, slv_addr);
        end
        exp_q.push_back('{64'hA5, 1'b0});
        next();
        idle();
        @(negedge clk);
        total++;
        if (mst_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL uart_early_rsp got rvalid=%b want 0", mst_rvalid);
        end
        next();
        slv_rvalid = 5'b00100;
        slv_rdata[2] = 64'hA5;
        next();
        idle();
        total++;
        if (dut.cnt !== 0) begin
            bad++;
            $display("FAIL uart_cnt got %0d want 0", dut.cnt);
        end
    endtask

    task automatic test_err_then_debug();
        mst_req = 1'b1;
        mst_addr = 64'h2000_0000;
        @(negedge clk);
        total++;
        if (mst_gnt !== 1'b1 || slv_req !== 5'b0) begin
            bad++;
            $display("FAIL err_grant got gnt=%b req=%b want 1/00000", mst_gnt, slv_req);
        end
        exp_q.push_back('{64'h0, 1'b1});
        next();
        mst_addr = 64'h0;
        slv_gnt = 5'b10000;
        @(negedge clk);
        total++;
        if (mst_rvalid !== 1'b1 || mst_gnt !== 1'b0 || slv_req !== 5'b0) begin
            bad++;
            $display("FAIL err_stall got rv=%b gnt=%b req=%b want 1/0/00000",
                     mst_rvalid, mst_gnt, slv_req);
        end
        next();
        @(negedge clk);
        total++;
        if (slv_req !== 5'b10000 || mst_gnt !== 1'b1) begin
            bad++;
            $display("FAIL debug_issue got req=%b gnt=%b want 10000/1", slv_req, mst_gnt);
        end
        exp_q.push_back('{64'h1234, 1'b0});
        next();
        idle();
        slv_rvalid = 5'b10000;
        slv_rdata[4] = 64'h1234;
        next();
        idle();
    endtask

    task automatic test_back_to_back();
        mst_req = 1'b1;
        slv_gnt = 5'b00001;
        for (int i = 0; i < 4; i++) begin
            mst_addr = 64'h8000_0000 + 64'(8 * i);
            @(negedge clk);
            total++;
            if (mst_gnt !== 1'b1 || slv_req !== 5'b00001) begin
                bad++;
                $display("FAIL b2b_grant%0d got gnt=%b req=%b want 1/00001", i, mst_gnt, slv_req);
            end
            exp_q.push_back('{64'hD000 + 64'(i), 1'b0});
            next();
        end
        mst_addr = 64'h8000_0020;
        @(negedge clk);
        total++;
        if (mst_gnt !== 1'b0 || slv_req !== 5'b0) begin
            bad++;
            $display("FAIL b2b_full_stall got gnt=%b req=%b want 0/00000", mst_gnt, slv_req);
        end
        next();
        slv_rvalid = 5'b00001;
        slv_rdata[0] = 64'hD000;
        @(negedge clk);
        total++;
        if (mst_gnt !== 1'b1 || slv_req !== 5'b00001) begin
            bad++;
            $display("FAIL b2b_unblock got gnt=%b req=%b want 1/00001", mst_gnt, slv_req);
        end
        exp_q.push_back('{64'hD004, 1'b0});
        next();
        total++;
        if (dut.cnt !== 4) begin
            bad++;
            $display("FAIL b2b_cnt_hold got %0d want 4", dut.cnt);
        end
        mst_req = 1'b0;
        slv_gnt = '0;
        for (int i = 1; i <= 4; i++) begin
            slv_rvalid = 5'b00001;
            slv_rdata[0] = 64'hD000 + 64'(i);
            next();
        end
        idle();
        total++;
        if (dut.cnt !== 0) begin
            bad++;
            $display("FAIL b2b_drain got cnt=%0d want 0", dut.cnt);
        end
    endtask

    task automatic test_switch_order();
        mst_req = 1'b1;
        mst_addr = 64'h4000_0000;
        slv_gnt = 5'b00010;
        @(negedge clk);
        total++;
        if (mst_gnt !== 1'b1 || slv_req !== 5'b00010) begin
            bad++;
            $display("FAIL gpio_issue got gnt=%b req=%b want 1/00010", mst_gnt, slv_req);
        end
        exp_q.push_back('{64'h6060, 1'b0});
        next();
        mst_addr = 64'h0200_0010;
        slv_gnt = 5'b01000;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) begin
                slv_rvalid = 5'b00010;
                slv_rdata[1] = 64'h6060;
            end
            @(negedge clk);
            total++;
            if (mst_gnt !== 1'b0 || slv_req !== 5'b0) begin
                bad++;
                $display("FAIL clint_hold%0d got gnt=%b req=%b want 0/00000", c, mst_gnt, slv_req);
            end
            next();
        end
        slv_rvalid = '0;
        @(negedge clk);
        total++;
        if (mst_gnt !== 1'b1 || slv_req !== 5'b01000) begin
            bad++;
            $display("FAIL clint_issue got gnt=%b req=%b want 1/01000", mst_gnt, slv_req);
        end
        exp_q.push_back('{64'hC1C1, 1'b1});
        next();
        idle();
        slv_rvalid = 5'b01000;
        slv_err = 5'b01000;
        slv_rdata[3] = 64'hC1C1;
        next();
        idle();
    endtask

    task automatic test_boundary();
        logic [63:0] addrs[4] = '{64'hBFFF_FFFF, 64'hC000_0000, 64'h020B_FFFF, 64'h020C_0000};
        logic [4:0]  reqs[4]  = '{5'b00001, 5'b00000, 5'b01000, 5'b00000};
        for (int i = 0; i < 4; i++) begin
            mst_req = 1'b1;
            mst_addr = addrs[i];
            slv_gnt = '1;
            @(negedge clk);
            total++;
            if (slv_req !== reqs[i] || mst_gnt !== 1'b1) begin
                bad++;
                $display("FAIL boundary_%h got req=%b gnt=%b want %b/1",
                         addrs[i], slv_req, mst_gnt, reqs[i]);
            end
            if (reqs[i] == 5'b0) exp_q.push_back('{64'h0, 1'b1});
            else                 exp_q.push_back('{64'hB000 + 64'(i), 1'b0});
            next();
            idle();
            if (reqs[i] != 5'b0) begin
                slv_rvalid = reqs[i];
                slv_rdata[0] = 64'hB000 + 64'(i);
                slv_rdata[3] = 64'hB000 + 64'(i);
            end
            next();
            idle();
        end
    endtask

    task automatic test_reset_mid();
        mst_req = 1'b1;
        slv_gnt = 5'b00001;
        mst_addr = 64'h8000_1000;
        next();
        mst_addr = 64'h8000_1008;
        next();
        rst_n = 1'b0;
        exp_q.delete();
        slv_rvalid = 5'b00001;
        slv_rdata[0] = 64'hDEAD;
        @(negedge clk);
        total++;
        if ({mst_gnt, mst_rvalid, mst_err, slv_req, mst_rdata} !== '0) begin
            bad++;
            $display("FAIL midreset_outputs got gnt=%b rv=%b err=%b req=%b rdata=%h want 0",
                     mst_gnt, mst_rvalid, mst_err, slv_req, mst_rdata);
        end
        next();
        rst_n = 1'b1;
        mst_req = 1'b0;
        @(negedge clk);
        total++;
        if (mst_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL late_rsp got rvalid=%b want 0", mst_rvalid);
        end
        next();
        slv_rvalid = '0;
        mst_req = 1'b1;
        mst_addr = 64'h8000_2000;
        @(negedge clk);
        total++;
        if (mst_gnt !== 1'b1 || slv_req !== 5'b00001) begin
            bad++;
            $display("FAIL post_reset_issue got gnt=%b req=%b want 1/00001", mst_gnt, slv_req);
        end
        exp_q.push_back('{64'hBEEF, 1'b0});
        next();
        idle();
        slv_rvalid = 5'b00001;
        slv_rdata[0] = 64'hBEEF;
        next();
        idle();
    endtask

    initial begin
        test_reset();
        test_uart_read();
        test_err_then_debug();
        test_back_to_back();
        test_switch_order();
        test_boundary();
        test_reset_mid();
        next();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL rsp_missing got %0d left want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
